phy_scan_mode_ctrl: RTL

//   Sequencer that drives the scan_mode_en_in pin of every phy_scan_mux in the PHY.

---
 rtl/phy_scan_pkg.sv | 38 +++
 rtl/phy_scan_mode_ctrl_settle_cnt.sv | 28 ++
 rtl/phy_scan_mode_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/phy_scan_pkg.sv
// Shared types for the PHY scan-mode sequencer: state encoding, default timings
// and the state-to-output decode.
package phy_scan_pkg;

  localparam int PHY_SCAN_RST_CYCLES    = 8;
  localparam int PHY_SCAN_SETTLE_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_FUNC      = 3'd0,
    ST_ENTER_RST = 3'd1,
    ST_ENTER_MUX = 3'd2,
    ST_SCAN      = 3'd3,
    ST_EXIT_RST  = 3'd4,
    ST_EXIT_MUX  = 3'd5
  } phy_scan_state_t;

  typedef struct packed {
    logic mode_en;
    logic fcn_rst;
    logic ack;
    logic busy;
  } phy_scan_outs_t;

  function automatic phy_scan_outs_t phy_scan_outs_of(input phy_scan_state_t st);
    phy_scan_outs_t o;
    case (st)
      ST_FUNC:      o = 4'b0000;
      ST_ENTER_RST: o = 4'b0101;
      ST_ENTER_MUX: o = 4'b1101;
      ST_SCAN:      o = 4'b1010;
      ST_EXIT_RST:  o = 4'b1101;
      ST_EXIT_MUX:  o = 4'b0101;
      default:      o = 4'b0000;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/phy_scan_mode_ctrl_settle_cnt.sv
// Loadable down-counter timing the reset and settle windows; saturates at zero.
import phy_scan_pkg::*;

module phy_scan_settle_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             load_in,
  input  logic [CNT_W-1:0] load_val_in,
  output logic             zero_out
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else if (load_in) begin
      cnt_q <= load_val_in;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_out = (cnt_q == '0);

endmodule

// File: rtl/phy_scan_mode_ctrl.sv
// Sequencer for the PHY scan-mux select: wraps every select change in a forced
// functional reset. Optional sticky scan lock under PHY_SCAN_LOCK_EN.
import phy_scan_pkg::*;

module phy_scan_mode_ctrl #(
  parameter int RST_CYCLES    = PHY_SCAN_RST_CYCLES,
  parameter int SETTLE_CYCLES = PHY_SCAN_SETTLE_CYCLES,
  parameter int CNT_W         = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       scan_req_in,
  output logic       scan_mode_en_out,
  output logic       fcn_rst_out,
  output logic       scan_ack_out,
  output logic       busy_out,
  output logic [2:0] state_out
);

  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  phy_scan_state_t  state_q, state_nxt;
  phy_scan_outs_t   outs_q;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;
  logic             lock_q;

  phy_scan_settle_cnt #(.CNT_W(CNT_W)) u_settle_cnt (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .load_in     (cnt_load),
    .load_val_in (cnt_load_val),
    .zero_out    (cnt_zero)
  );

  // Counter is loaded on the same edge the FSM enters a timed state
  always_comb begin
    state_nxt    = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      ST_FUNC: if (scan_req_in) begin
        state_nxt    = ST_ENTER_RST;
        cnt_load     = 1'b1;
        cnt_load_val = RST_LOAD;
      end
      ST_ENTER_RST: if (cnt_zero) begin
        state_nxt    = ST_ENTER_MUX;
        cnt_load     = 1'b1;
        cnt_load_val = SETTLE_LOAD;
      end
      ST_ENTER_MUX: if (cnt_zero) state_nxt = ST_SCAN;
      ST_SCAN: if (!scan_req_in && !lock_q) begin
        state_nxt    = ST_EXIT_RST;
        cnt_load     = 1'b1;
        cnt_load_val = RST_LOAD;
      end
      ST_EXIT_RST: if (cnt_zero) begin
        state_nxt    = ST_EXIT_MUX;
        cnt_load     = 1'b1;
        cnt_load_val = SETTLE_LOAD;
      end
      ST_EXIT_MUX: if (cnt_zero) state_nxt = ST_FUNC;
      default: state_nxt = ST_FUNC;
    endcase
  end

`ifndef PHY_SCAN_LOCK_EN
  assign lock_q = 1'b0;
`endif

  // Outputs decoded from the next state so they line up with state_q
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_FUNC;
      outs_q  <= '0;
`ifdef PHY_SCAN_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_nxt;
      outs_q  <= phy_scan_outs_of(state_nxt);
`ifdef PHY_SCAN_LOCK_EN
      if (state_nxt == ST_SCAN) lock_q <= 1'b1;
`endif
    end
  end

  assign scan_mode_en_out = outs_q.mode_en;
  assign fcn_rst_out      = outs_q.fcn_rst;
  assign scan_ack_out     = outs_q.ack;
  assign busy_out         = outs_q.busy;
  assign state_out        = state_q;

endmodule
